// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter between the CPU
// load/store path and the peripheral requester.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FORCE
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the arbiter: CPU port, peripheral port and RAM port.
// slave is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              cpu_req;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic [DATA_W-1:0] cpu_q;
  logic              cpu_stall;

  logic              per_req;
  logic              per_we;
  logic [ADDR_W-1:0] per_addr;
  logic [DATA_W-1:0] per_wdata;
  logic              per_gnt;
  logic              per_rvalid;
  logic [DATA_W-1:0] per_rdata;

  logic              ram_wEn;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dataIn;
  logic [DATA_W-1:0] ram_dataOut;

  modport slave (
    input  cpu_req, cpu_wren, cpu_addr, cpu_data,
    input  per_req, per_we, per_addr, per_wdata,
    input  ram_dataOut,
    output cpu_q, cpu_stall,
    output per_gnt, per_rvalid, per_rdata,
    output ram_wEn, ram_addr, ram_dataIn
  );

  modport master (
    output cpu_req, cpu_wren, cpu_addr, cpu_data,
    output per_req, per_we, per_addr, per_wdata,
    output ram_dataOut,
    input  cpu_q, cpu_stall,
    input  per_gnt, per_rvalid, per_rdata,
    input  ram_wEn, ram_addr, ram_dataIn
  );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating wait counter for a pending peripheral request; at_limit_o
// flags that the count reaches LIMIT on the coming edge.
module starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: assign a default before any branch so the combinational block cannot infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign at_limit_o = (cnt_d == LIMIT_C);

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter: CPU has priority, a starvation counter forces
// a one-cycle CPU stall so a waiting peripheral is served within MAX_WAIT cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 8
) (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d;
  logic              per_own;
  logic              cnt_clr;
  logic              at_limit;
  logic              mux_wen;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;
  logic              per_rvalid_q;
  logic [DATA_W-1:0] per_rdata_q;

  starve_counter #(.LIMIT(MAX_WAIT)) u_starve (
    .clock      (clock),
    .reset      (reset),
    .clr_i      (cnt_clr),
    .inc_i      (~cnt_clr),
    .at_limit_o (at_limit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A grant or a withdrawn request both end the wait; otherwise keep waiting
  // and escalate once the counter reaches the limit.
  always_comb begin
    state_d = state_q;
    if (cnt_clr) begin
      state_d = IDLE;
    end else if (at_limit) begin
      state_d = FORCE;
    end else begin
      state_d = WAIT;
    end
  end

  always_comb begin
    per_own   = bus.per_req & (~bus.cpu_req | (state_q == FORCE));
    mux_wen   = bus.cpu_req & bus.cpu_wren;
    mux_addr  = bus.cpu_addr;
    mux_wdata = bus.cpu_data;
    if (per_own) begin
      mux_wen   = bus.per_we;
      mux_addr  = bus.per_addr;
      mux_wdata = bus.per_wdata;
    end
  end

  assign cnt_clr        = per_own | ~bus.per_req;
  assign bus.per_gnt    = per_own;
  assign bus.cpu_stall  = per_own & bus.cpu_req;
  assign bus.ram_wEn    = mux_wen;
  assign bus.ram_addr   = mux_addr;
  assign bus.ram_dataIn = mux_wdata;
  assign bus.cpu_q      = bus.ram_dataOut;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      per_rvalid_q <= 1'b0;
      per_rdata_q  <= '0;
    end else begin
      per_rvalid_q <= per_own & ~bus.per_we;
      if (per_rvalid_q) begin
        per_rdata_q <= bus.ram_dataOut;
      end
    end
  end

  // RAM data is live during the valid cycle; the register holds it afterwards.
  assign bus.per_rvalid = per_rvalid_q;
  assign bus.per_rdata  = per_rvalid_q ? bus.ram_dataOut : per_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus queues expected grants,
// writes and read data; a negedge monitor pops and compares as the DUT responds.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 8;

  localparam logic [DATA_W-1:0] D_SPR  = 32'hCAFE_0020;
  localparam logic [DATA_W-1:0] D_LOAD = 32'h1234_5678;

  typedef struct {
    int   cyc;
    logic stall;
  } gnt_exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;

  int vectors     = 0;
  int miscompares = 0;
  int stall_seen  = 0;

  gnt_exp_t                   gnt_q[$];
  logic [DATA_W-1:0]          rv_q[$];
  logic [DATA_W-1:0]          rd_q[$];
  logic [ADDR_W+DATA_W-1:0]   wr_q[$];

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              cpu_rd_pend = 1'b0;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous single-port RAM model: read data one cycle after the address.
  always @(posedge clock) begin
    if (bus.ram_wEn) mem[bus.ram_addr] <= bus.ram_dataIn;
    bus.ram_dataOut <= mem[bus.ram_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event seen at cycle %0d, none expected", name, cyc);
  endtask

  // Monitor: every DUT-presented event is matched against the queues.
  always @(negedge clock) begin
    if (!reset) begin
      cpu_rd_pend = 1'b0;
    end else begin
      if (cpu_rd_pend) begin
        if (rd_q.size() == 0) flag("cpu_rd_unexpected");
        else check("cpu_q", 64'(bus.cpu_q), 64'(rd_q.pop_front()));
      end
      cpu_rd_pend = bus.cpu_req & ~bus.cpu_wren & ~bus.cpu_stall;
      if (bus.ram_wEn) begin
        if (wr_q.size() == 0) flag("ram_write_unexpected");
        else check("ram_write", 64'({bus.ram_addr, bus.ram_dataIn}), 64'(wr_q.pop_front()));
      end
      if (bus.cpu_stall) stall_seen++;
      if (bus.per_gnt) begin
        if (gnt_q.size() == 0) begin
          flag("per_gnt_unexpected");
        end else begin
          gnt_exp_t e;
          e = gnt_q.pop_front();
          check("per_gnt_cycle", 64'(cyc), 64'(e.cyc));
          check("cpu_stall", 64'(bus.cpu_stall), 64'(e.stall));
        end
      end else if (bus.cpu_stall) begin
        flag("cpu_stall_without_gnt");
      end
      if (bus.per_rvalid) begin
        if (rv_q.size() == 0) flag("per_rvalid_unexpected");
        else check("per_rdata", 64'(bus.per_rdata), 64'(rv_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_drive(input logic req, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    bus.cpu_req  = req;
    bus.cpu_wren = wr;
    bus.cpu_addr = a;
    bus.cpu_data = d;
  endtask

  task automatic per_drive(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    bus.per_req   = req;
    bus.per_we    = we;
    bus.per_addr  = a;
    bus.per_wdata = d;
  endtask

  task automatic exp_gnt(input int c, input logic s);
    gnt_exp_t e;
    e.cyc   = c;
    e.stall = s;
    gnt_q.push_back(e);
  endtask

  task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_q.push_back({a, d});
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int s0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[12'h020] = D_SPR;
    mem[12'h200] = D_LOAD;
    cpu_drive(1'b0, 1'b0, '0, '0);
    per_drive(1'b0, 1'b0, '0, '0);

    // Reset state
    step();
    step();
    check("rst_per_rvalid", 64'(bus.per_rvalid), 64'(0));
    check("rst_per_rdata", 64'(bus.per_rdata), 64'(0));
    check("rst_state", 64'(dut.state_q), 64'(IDLE));
    check("rst_wait_cnt", 64'(dut.u_starve.cnt_q), 64'(0));
    reset = 1'b1;
    step();

    // CPU idle: peripheral write granted immediately, then CPU reads it back
    per_drive(1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF);
    exp_gnt(cyc, 1'b0);
    exp_wr(12'h010, 32'hDEAD_BEEF);
    step();
    per_drive(1'b0, 1'b0, '0, '0);
    cpu_drive(1'b1, 1'b0, 12'h010, '0);
    rd_q.push_back(32'hDEAD_BEEF);
    step();
    cpu_drive(1'b0, 1'b0, '0, '0);
    step();

    // Continuous CPU load: peripheral read forced on cycle 8, data on cycle 9
    n = cyc;
    cpu_drive(1'b1, 1'b0, 12'h200, '0);
    per_drive(1'b1, 1'b0, 12'h020, '0);
    exp_gnt(n + 8, 1'b1);
    rv_q.push_back(D_SPR);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) check("t2_wait_cnt_mid", 64'(dut.u_starve.cnt_q), 64'(4));
      if (k == 8) begin
        check("t2_wait_cnt_sat", 64'(dut.u_starve.cnt_q), 64'(8));
        check("t2_state_force", 64'(dut.state_q), 64'(FORCE));
      end
      if (k == 9) per_drive(1'b0, 1'b0, '0, '0);
      if (k != 8) rd_q.push_back(D_LOAD);
      step();
    end
    cpu_drive(1'b0, 1'b0, '0, '0);
    step();

    // Simultaneous writes: CPU first, peripheral on the next (idle) cycle
    n = cyc;
    cpu_drive(1'b1, 1'b1, 12'h030, 32'h3030_3030);
    per_drive(1'b1, 1'b1, 12'h031, 32'h3131_3131);
    exp_wr(12'h030, 32'h3030_3030);
    step();
    check("t3_state_wait", 64'(dut.state_q), 64'(WAIT));
    cpu_drive(1'b0, 1'b0, '0, '0);
    exp_gnt(n + 1, 1'b0);
    exp_wr(12'h031, 32'h3131_3131);
    step();
    per_drive(1'b0, 1'b0, '0, '0);
    cpu_drive(1'b1, 1'b0, 12'h030, '0);
    rd_q.push_back(32'h3030_3030);
    step();
    cpu_drive(1'b1, 1'b0, 12'h031, '0);
    rd_q.push_back(32'h3131_3131);
    step();
    cpu_drive(1'b0, 1'b0, '0, '0);
    step();

    // Read granted, then reset before the next edge: no per_rvalid afterwards
    per_drive(1'b1, 1'b0, 12'h020, '0);
    exp_gnt(cyc, 1'b0);
    @(negedge clock);
    #1;
    reset = 1'b0;
    per_drive(1'b0, 1'b0, '0, '0);
    #1;
    check("t4_rst_rdata", 64'(bus.per_rdata), 64'(0));
    step();
    check("t4_rst_rvalid", 64'(bus.per_rvalid), 64'(0));
    step();
    reset = 1'b1;
    step();
    step();
    check("t4_state_idle", 64'(dut.state_q), 64'(IDLE));
    check("t4_wait_cnt", 64'(dut.u_starve.cnt_q), 64'(0));

    // Request withdrawn after 3 cycles under CPU load: no grant, no write
    cpu_drive(1'b1, 1'b0, 12'h200, '0);
    per_drive(1'b1, 1'b1, 12'h040, 32'h4040_4040);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        check("t5_wait_cnt", 64'(dut.u_starve.cnt_q), 64'(2));
        check("t5_state_wait", 64'(dut.state_q), 64'(WAIT));
      end
      rd_q.push_back(D_LOAD);
      step();
    end
    per_drive(1'b0, 1'b0, '0, '0);
    rd_q.push_back(D_LOAD);
    step();
    check("t5_wait_cnt_clr", 64'(dut.u_starve.cnt_q), 64'(0));
    check("t5_state_idle", 64'(dut.state_q), 64'(IDLE));
    cpu_drive(1'b1, 1'b0, 12'h040, '0);
    rd_q.push_back(32'h0);
    step();
    cpu_drive(1'b0, 1'b0, '0, '0);
    step();

    // Peripheral holds per_req under continuous CPU load: grant every 9th cycle
    s0 = stall_seen;
    n  = cyc;
    cpu_drive(1'b1, 1'b0, 12'h200, '0);
    per_drive(1'b1, 1'b0, 12'h020, '0);
    for (int k = 0; k < 29; k++) begin
      if (k == 27) per_drive(1'b0, 1'b0, '0, '0);
      if (k == 28) cpu_drive(1'b0, 1'b0, '0, '0);
      if ((k % 9 == 8) && (k < 27)) begin
        exp_gnt(n + k, 1'b1);
        rv_q.push_back(D_SPR);
      end
      if ((k < 28) && (k % 9 != 8)) rd_q.push_back(D_LOAD);
      step();
    end
    check("t6_stall_count", 64'(stall_seen - s0), 64'(3));

    step();
    step();
    step();
    check("left_gnt", 64'(gnt_q.size()), 64'(0));
    check("left_rvalid", 64'(rv_q.size()), 64'(0));
    check("left_cpu_rd", 64'(rd_q.size()), 64'(0));
    check("left_write", 64'(wr_q.size()), 64'(0));
    check("total_stalls", 64'(stall_seen), 64'(4));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
